// File: rtl/arith_pkg.sv
// -----------------------------------------------------------------------------
// arith_pkg
// Shared definitions for the arithmetic unit.
//   state_e   : sequencing states of the shift-and-add multiplier
//   DATA_W    : operand width, fixed to match adder_8bits
//   ITER      : number of shift-and-add iterations per multiply
//   LAST_ITER : counter value of the final iteration
// -----------------------------------------------------------------------------
package arith_pkg;

    localparam int DATA_W = 8;
    localparam int ITER   = 8;

    // Iteration counter is 3 bits wide; the final iteration is seen as ITER-1.
    localparam logic [2:0] LAST_ITER = 3'(ITER - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage : arith_pkg

// File: rtl/adder_8bits.sv
// -----------------------------------------------------------------------------
// adder_8bits
// Purely combinational 8-bit ripple adder: {Cout, S} = A + B + Cin.
//   A, B : 8-bit addends
//   Cin  : carry in
//   S    : 8-bit sum
//   Cout : carry out
// -----------------------------------------------------------------------------
module adder_8bits
    import arith_pkg::*;
(
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic              Cin,
    output logic [DATA_W-1:0] S,
    output logic              Cout
);

    logic [DATA_W:0] sum_w;

    always_comb begin
        sum_w = {1'b0, A} + {1'b0, B} + {{DATA_W{1'b0}}, Cin};
    end

    assign S    = sum_w[DATA_W-1:0];
    assign Cout = sum_w[DATA_W];

endmodule : adder_8bits

// File: rtl/mult_8bits_seq.sv
// -----------------------------------------------------------------------------
// mult_8bits_seq
// Sequential 8x8 unsigned shift-and-add multiplier, 16-bit product, one
// iteration per clock for 8 clocks.
//
// Ports:
//   clk    : single clock, rising edge
//   rst_n  : synchronous active-low reset
//   start  : request, only looked at while IDLE
//   A, B   : multiplicand / multiplier, captured when start is accepted
//   busy   : high while iterating (CALC)
//   done   : one-cycle pulse after the final iteration (DONE)
//   P      : product register, holds the last result until the next one
//
// Handshake: a request is accepted on any rising edge where the block is IDLE
// and start is high. busy rises after that edge and stays high for exactly 8
// cycles; done then pulses for one cycle, with P already valid. start outside
// IDLE is ignored (no queuing), and A/B are only sampled at acceptance. The
// earliest following acceptance is the edge after done drops (one op per 10
// cycles).
// -----------------------------------------------------------------------------
module mult_8bits_seq
    import arith_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [DATA_W-1:0]   A,
    input  logic [DATA_W-1:0]   B,
    output logic                busy,
    output logic                done,
    output logic [2*DATA_W-1:0] P
);

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    state_e              state_q, state_d;
    logic [DATA_W-1:0]   m_q,     m_d;      // multiplicand
    logic [DATA_W-1:0]   acc_q,   acc_d;    // high half of running product
    logic [DATA_W-1:0]   q_q,     q_d;      // low half / remaining multiplier
    logic [2:0]          cnt_q,   cnt_d;    // iteration counter
    logic [2*DATA_W-1:0] p_q,     p_d;      // product output register

    // -------------------------------------------------------------------------
    // Partial-product accumulation through the shared adder
    // -------------------------------------------------------------------------
    logic [DATA_W-1:0] add_b;
    logic [DATA_W-1:0] add_s;
    logic              add_cout;

    // Add the multiplicand only when the current multiplier LSB is set.
    assign add_b = q_q[0] ? m_q : '0;

    adder_8bits u_adder (
        .A    (acc_q),
        .B    (add_b),
        .Cin  (1'b0),
        .S    (add_s),
        .Cout (add_cout)
    );

    // {Cout, S, Q} shifted right by one: the carry becomes the new acc MSB and
    // the adder's LSB shifts into Q's MSB, so no carry is ever lost.
    logic [2*DATA_W-1:0] shifted;
    assign shifted = {add_cout, add_s, q_q[DATA_W-1:1]};

    // -------------------------------------------------------------------------
    // Next-state / datapath logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        acc_d   = acc_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        p_d     = p_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    m_d     = A;
                    q_d     = B;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end

            CALC: begin
                acc_d = shifted[2*DATA_W-1:DATA_W];
                q_d   = shifted[DATA_W-1:0];
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == LAST_ITER) begin
                    // P takes the post-shift value of this final iteration.
                    p_d     = shifted;
                    state_d = DONE;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers, synchronous active-low reset
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            m_q     <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs are straight decodes of registered state, so they never glitch
    // and busy/done are mutually exclusive by construction.
    // -------------------------------------------------------------------------
    assign busy = (state_q == CALC);
    assign done = (state_q == DONE);
    assign P    = p_q;

endmodule : mult_8bits_seq
